// File: rtl/run_control.sv
// run_control: core-side sequencer for the execution start interface.
// Turns the synchronized exec level and the exec_reset hold pulse into core
// reset, run enable, pause and halt controls for the CPU datapath. It reports
// halted/done status and counts the cycles in which the core advanced.
//
// Optional feature (macro RUN_CONTROL_STEP_EN): adds a `step` input. Each
// rising edge of step while paused lets the core advance for exactly one cycle.
//
// Handshake note: there is no valid/ready pairing here. Every input is a level
// sampled on each rising clock edge. Every output is a register that reflects
// the state entered at the most recent edge.
module run_control #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             exec_sig,
    input  logic             exec_reset,
    input  logic             halt_req,
`ifdef RUN_CONTROL_STEP_EN
    input  logic             step,
`endif
    output logic             run,
    output logic             core_reset,
    output logic             halted,
    output logic             done_pulse,
    output logic [CNT_W-1:0] cycle_count,
    output logic             overflow,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_HALTED = 3'd4
`ifdef RUN_CONTROL_STEP_EN
        ,
        ST_STEP   = 3'd5
`endif
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             run_q, run_d;
    logic             core_reset_q, core_reset_d;
    logic             halted_q, halted_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

`ifdef RUN_CONTROL_STEP_EN
    logic             step_q;
    logic             step_rise;

    // A step press counts once, on its rising edge only.
    assign step_rise = step & ~step_q;
`endif

    // Next-state selection. exec_reset overrides everything below reset.
    // halt_req outranks the exec level while the core is advancing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                // The hold pulse has ended. A low exec level here means the
                // start was abandoned.
                state_d = exec_sig ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALTED;
                end else if (!exec_sig) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                // halt_req is meaningless here because the core is frozen.
                if (exec_sig) begin
                    state_d = ST_RUN;
                end
`ifdef RUN_CONTROL_STEP_EN
                else if (step_rise) begin
                    state_d = ST_STEP;
                end
`endif
            end
`ifdef RUN_CONTROL_STEP_EN
            ST_STEP: begin
                // The core executes a single instruction cycle, then pauses
                // again unless that instruction was HLT.
                state_d = halt_req ? ST_HALTED : ST_PAUSE;
            end
`endif
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (exec_reset) begin
            state_d = ST_CLEAR;
        end
    end

    // Registered outputs are decoded from the state being entered, so they
    // change on the same edge as the state itself.
    always_comb begin
        run_d        = (state_d == ST_RUN);
`ifdef RUN_CONTROL_STEP_EN
        run_d        = run_d | (state_d == ST_STEP);
`endif
        core_reset_d = (state_d == ST_CLEAR);
        halted_d     = (state_d == ST_HALTED);
        // HALTED can only be entered from an advancing state, so the first
        // HALTED cycle is exactly a state change into it.
        done_d       = (state_d == ST_HALTED) && (state_q != ST_HALTED);
    end

    // Cycle counter. It counts the cycle that just ended if the core advanced
    // in it (run_q high), saturates at all-ones with a sticky overflow, and
    // restarts whenever CLEAR is entered.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (run_q) begin
            if (&count_q) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end
        if (state_d == ST_CLEAR) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            run_q        <= 1'b0;
            core_reset_q <= 1'b0;
            halted_q     <= 1'b0;
            done_q       <= 1'b0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            run_q        <= run_d;
            core_reset_q <= core_reset_d;
            halted_q     <= halted_d;
            done_q       <= done_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef RUN_CONTROL_STEP_EN
    // Previous step level, used for rising-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end
`endif

    assign run         = run_q;
    assign core_reset  = core_reset_q;
    assign halted      = halted_q;
    assign done_pulse  = done_q;
    assign cycle_count = count_q;
    assign overflow    = ovf_q;
    assign state_dbg   = state_q;

    // The core must never be enabled while it is being held in reset.
    a_run_excl_reset: assert property (@(posedge clock) !(run_q && core_reset_q));

    // done_pulse lasts a single cycle.
    a_done_single: assert property (@(posedge clock) disable iff (reset)
        done_q |=> !done_q);

endmodule

// File: tb/tb_run_control.sv
// tb_run_control: scoreboard bench for run_control. The driver applies one
// input vector per clock and pushes the response predicted by a behavioural
// model. The monitor pops one prediction after each edge and compares it with
// the DUT outputs.
module tb_run_control;
  localparam int TW = 4;
  localparam int EW = TW + 5;
  localparam int unsigned CMAX = (1 << TW) - 1;

`ifdef RUN_CONTROL_STEP_EN
  localparam bit HAS_STEP = 1'b1;
`else
  localparam bit HAS_STEP = 1'b0;
`endif

  // model phases
  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_RUN   = 2;
  localparam int P_PAUSE = 3;
  localparam int P_HALT  = 4;
  localparam int P_STEP  = 5;

  // ---------------- clock / reset / DUT ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic exec_sig = 1'b0;
  logic exec_reset = 1'b0;
  logic halt_req = 1'b0;
  logic step = 1'b0;
  logic run, core_reset, halted, done_pulse, overflow;
  logic [TW-1:0] cycle_count;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  run_control #(.CNT_W(TW)) dut (
    .clock(clock),
    .reset(reset),
    .exec_sig(exec_sig),
    .exec_reset(exec_reset),
    .halt_req(halt_req),
`ifdef RUN_CONTROL_STEP_EN
    .step(step),
`endif
    .run(run),
    .core_reset(core_reset),
    .halted(halted),
    .done_pulse(done_pulse),
    .cycle_count(cycle_count),
    .overflow(overflow),
    .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  int          m_phase = P_IDLE;
  int unsigned m_cnt = 0;
  bit          m_ovf = 1'b0;
  bit          m_done = 1'b0;
  bit          m_sprev = 1'b0;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Advance the model across one clock edge with the given inputs applied.
  task automatic model_edge(input bit rs, input bit es, input bit er, input bit hr, input bit st);
    bit advanced;
    if (rs) begin
      m_phase = P_IDLE;
      m_cnt = 0;
      m_ovf = 1'b0;
      m_done = 1'b0;
      m_sprev = 1'b0;
    end else begin
      advanced = (m_phase == P_RUN) || (m_phase == P_STEP);
      if (advanced) begin
        if (m_cnt == CMAX) m_ovf = 1'b1;
        else m_cnt = m_cnt + 1;
      end
      m_done = 1'b0;
      if (er) begin
        m_phase = P_CLEAR;
      end else begin
        case (m_phase)
          P_CLEAR: m_phase = es ? P_RUN : P_IDLE;
          P_RUN: begin
            if (hr) begin m_phase = P_HALT; m_done = 1'b1; end
            else if (!es) m_phase = P_PAUSE;
          end
          P_PAUSE: begin
            if (es) m_phase = P_RUN;
            else if (HAS_STEP && st && !m_sprev) m_phase = P_STEP;
          end
          P_STEP: begin
            if (hr) begin m_phase = P_HALT; m_done = 1'b1; end
            else m_phase = P_PAUSE;
          end
          default: ;
        endcase
      end
      if (m_phase == P_CLEAR) begin
        m_cnt = 0;
        m_ovf = 1'b0;
      end
      m_sprev = st;
    end
  endtask

  function automatic logic [EW-1:0] model_outputs();
    logic [TW-1:0] c;
    c = TW'(m_cnt);
    return {(m_phase == P_RUN) || (m_phase == P_STEP), m_phase == P_CLEAR,
            m_phase == P_HALT, m_done, m_ovf, c};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit rs, input bit es, input bit er, input bit hr, input bit st);
    reset = rs;
    exec_sig = es;
    exec_reset = er;
    halt_req = hr;
    step = st;
    model_edge(rs, es, er, hr, st);
    exp_q.push_back(model_outputs());
    @(posedge clock);
    #2;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] e;
    logic [EW-1:0] got;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = {run, core_reset, halted, done_pulse, overflow, cycle_count};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL outputs cyc=%0d got run=%b crst=%b halted=%b done=%b ovf=%b cnt=%0d want run=%b crst=%b halted=%b done=%b ovf=%b cnt=%0d",
                   cyc, got[EW-1], got[EW-2], got[EW-3], got[EW-4], got[EW-5], got[TW-1:0],
                   e[EW-1], e[EW-2], e[EW-3], e[EW-4], e[EW-5], e[TW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int er_hold;
    bit es, hr, st, rs;

    // reset
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0);

    // start: 6-cycle hold, then 10 cycles of running
    repeat (6) drive(0, 1, 1, 0, 0);
    repeat (10) drive(0, 1, 0, 0, 0);

    // HLT, then extra halt_req and exec_sig activity while halted
    drive(0, 1, 0, 1, 0);
    repeat (3) drive(0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 1, 0, 0, 0);

    // restart from HALTED, run, pause 4 cycles (halt ignored), resume
    repeat (6) drive(0, 1, 1, 0, 0);
    repeat (5) drive(0, 1, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    repeat (5) drive(0, 1, 0, 0, 0);

    // saturation, then exec_reset together with halt_req, then aborted start
    repeat (20) drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 0);
    repeat (5) drive(0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    repeat (2) drive(0, 1, 0, 1, 0);

    // step presses while paused (ignored when the feature is absent)
    repeat (6) drive(0, 1, 1, 0, 0);
    repeat (3) drive(0, 1, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0);
    repeat (3) begin
      drive(0, 0, 0, 0, 1);
      repeat (2) drive(0, 0, 0, 0, 0);
    end
    repeat (10) drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 1);
    repeat (3) drive(0, 0, 0, 0, 0);

    // randomized traffic
    er_hold = 0;
    es = 1'b0;
    st = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (er_hold == 0 && $urandom_range(0, 40) == 0) er_hold = $urandom_range(1, 8);
      if ($urandom_range(0, 15) == 0) es = ~es;
      if ($urandom_range(0, 3) == 0) st = ~st;
      hr = ($urandom_range(0, 30) == 0);
      rs = ($urandom_range(0, 500) == 0);
      drive(rs, es, er_hold > 0, hr, st);
      if (er_hold > 0) er_hold--;
    end

    // every prediction must have been consumed by the monitor
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
